matrix_multiply_param: RTL and testbench
========================================

# matrix_multiply_param

Parametrised N×N integer matrix multiplier and successor to the fixed 3×3 unsigned multiplier in the UART matrix datapath. It accepts two packed matrices through a valid/ready handshake and computes C = A·B with a single time-multiplexed multiply-accumulate (MAC) unit, one product per cycle. It presents the packed result through a second valid/ready handshake that holds the result under back-pressure. It sits between the UART frame unpacker and the result serializer.

## Interface
- `N`, default 3: matrix dimension; legal range 2..8.
- `W`, default 3: element width in bits.
- `SIGNED`, default 0: 0 = unsigned elements; 1 = two's-complement elements and result.
- `RW` (localparam) = 2·W + clog2(N): result element width; 8 for the defaults.
- `clk` in 1: the single clock; all logic is clocked on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `in_valid` in 1: the operand pair is valid.
- `in_ready` out 1: the block can accept operands.
- `mat_a` in N·N·W: matrix A; element (r,c) is at bits [(r·N+c)·W +: W].
- `mat_b` in N·N·W: matrix B; same packing as `mat_a`.
- `out_valid` out 1: `result` is valid.
- `out_ready` in 1: the consumer accepts `result`.
- `result` out N·N·RW: matrix C; element (r,c) is at bits [(r·N+c)·RW +: RW].
- `busy` out 1: high in the COMPUTE state.
- `state` out 2: current FSM state, for debug.

## Operation
- FSM states: IDLE=0, COMPUTE=1, DONE=2. Encoding 3 is illegal and returns to IDLE on the next edge.
- **IDLE**
  - `in_ready`=1.
  - When `in_valid`&`in_ready`: capture `mat_a` and `mat_b` into internal registers, clear the accumulator, set the counters r=c=k=0, and go to COMPUTE.
- **COMPUTE**
  - Each cycle: acc ← acc + A[r][k]·B[k][c].
  - Operands are zero-extended when SIGNED=0 and sign-extended when SIGNED=1, to RW bits.
  - When k=N−1: write acc+product into C[r][c], clear acc, set k=0, and advance c, then r, in row-major order.
  - Otherwise: k ← k+1.
  - After the product for C[N−1][N−1], k=N−1 is written, go to DONE.
- **DONE**
  - `out_valid`=1 and `result` reflects the C register.
  - When `out_ready`=1: go to IDLE.
- Width rule: RW is wide enough for the worst-case sum in both modes, so no overflow or saturation logic is needed.
- `result` holds its last value after the handoff and updates only at the next COMPUTE→DONE transition.
- Operand changes on `mat_a`/`mat_b` outside the capture cycle have no effect.
- `in_valid` outside IDLE is ignored. There is no queueing; the upstream stage must hold its operands.

## Timing
- Reset (`rst_n`=0 at an edge):
  - `state`=IDLE; `out_valid`=0; `busy`=0; `result`=0; C, acc and counters cleared.
  - `in_ready`=1 from the first edge with `rst_n` high.
  - Reset mid-COMPUTE or in DONE aborts the operation; no partial result is ever presented.
- Latency:
  - The capture edge is E0.
  - `busy` is high from E0 to E0+N³.
  - `out_valid` rises after edge E0+N³; for N=3 that is 27 cycles.
- Throughput: one operation per N³+2 cycles when `out_ready` is tied high.
- `out_valid`&`out_ready` in the same cycle: `out_valid`=0 and `in_ready`=1 from the next edge.
- `in_ready` is low in COMPUTE and DONE. A new capture is possible only the cycle after the handoff.
- All outputs are registered or decoded directly from `state`. There is no combinational path from `in_valid` or `out_ready` to any output.

## Structure
- Package `matmul_pkg` holds:
  - the state encoding constants (IDLE/COMPUTE/DONE);
  - a clog2 function;
  - the RW derivation.
- Sub-module `mac_unit` (`W`, `RW`, `SIGNED`):
  - extends the operands and multiplies them;
  - adds the product to the accumulator input;
  - is combinational, with the accumulator register held in the parent.
- The parent holds the FSM, the r/c/k counters, the operand registers and the C register file.

## Test plan
- Identity × sequence: N=3, W=4, A=I, B=1..9 → `result` elements 1..9, `out_valid` 27 cycles after capture.
- Worst-case unsigned: N=3, W=3, all elements 7 → every C element = 147 (8'h93), with no overflow.
- Signed: SIGNED=1, N=3, W=3, all elements 3'b100 (−4) → every C element = +48. A second run with B all 3'b011 (+3) → every C element = −36 (8'hDC).
- Back-pressure: hold `out_ready`=0 for 10 cycles in DONE → `result` stable, `out_valid`=1, `in_ready`=0, and `in_valid` pulses ignored. Then `out_ready`=1 → IDLE on the next edge.
- Reset mid-COMPUTE: drive `rst_n`=0 at cycle 10 of COMPUTE → IDLE with `result`=0 and `out_valid`=0. The following operation with fresh operands matches the reference model exactly.
- Back-to-back, randomized: N∈{2,4}, `out_ready` tied high, 100 random operand pairs in both modes → every result matches a software model, and the capture cadence is N³+2 cycles.

Source files
------------

// File: rtl/matmul_pkg.sv
// -----------------------------------------------------------------------------
// matmul_pkg
// Shared definitions for the parametrised matrix multiplier:
//   - state_e  : FSM state encoding (IDLE=0, COMPUTE=1, DONE=2; 3 is illegal)
//   - clog2    : ceiling log2 usable in constant expressions
//   - calc_rw  : result element width, 2*W + clog2(N)
// -----------------------------------------------------------------------------
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    // Smallest r such that 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int res;
        int pow;
        res = 32'sd0;
        pow = 32'sd1;
        for (int i = 0; i < 31; i++) begin
            if (pow < value) begin
                res = res + 32'sd1;
                pow = pow * 32'sd2;
            end
        end
        return res;
    endfunction

    // A full dot product of N terms of W x W bits fits in 2W + clog2(N) bits,
    // in both the unsigned and the two's-complement interpretation.
    function automatic int calc_rw(input int n, input int w);
        return (32'sd2 * w) + clog2(n);
    endfunction

endpackage

// File: rtl/mac_unit.sv
// -----------------------------------------------------------------------------
// mac_unit
// Combinational multiply-accumulate slice: sum_o = acc_i + ext(a_i) * ext(b_i).
// Operands are zero- or sign-extended to RW bits depending on SIGNED. The
// accumulator register lives in the parent.
//   a_i, b_i : W-bit operands
//   acc_i    : RW-bit running sum
//   sum_o    : RW-bit updated sum
// -----------------------------------------------------------------------------
module mac_unit #(
    parameter int W      = 3,
    parameter int RW     = 8,
    parameter int SIGNED = 0
) (
    input  logic [W-1:0]  a_i,
    input  logic [W-1:0]  b_i,
    input  logic [RW-1:0] acc_i,
    output logic [RW-1:0] sum_o
);

    logic [RW-1:0] a_ext_s;
    logic [RW-1:0] b_ext_s;
    logic [RW-1:0] prod_s;

    if (SIGNED != 0) begin : g_sext
        assign a_ext_s = {{(RW-W){a_i[W-1]}}, a_i};
        assign b_ext_s = {{(RW-W){b_i[W-1]}}, b_i};
    end else begin : g_zext
        assign a_ext_s = {{(RW-W){1'b0}}, a_i};
        assign b_ext_s = {{(RW-W){1'b0}}, b_i};
    end

    // The low RW bits of a product are identical for signed and unsigned
    // operands once both are extended to RW bits, so one multiplier serves both.
    assign prod_s = a_ext_s * b_ext_s;
    assign sum_o  = acc_i + prod_s;

endmodule

// File: rtl/matrix_multiply_param.sv
// -----------------------------------------------------------------------------
// matrix_multiply_param
// N x N integer matrix multiplier, C = A * B, using one time-multiplexed MAC
// (one product per cycle, N^3 cycles per operation).
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake; mat_a, mat_b captured on accept
//   mat_a, mat_b         : packed N*N*W operands, element (r,c) at (r*N+c)*W
//   out_valid / out_ready: result handshake; result held under back-pressure
//   result               : packed N*N*RW product, element (r,c) at (r*N+c)*RW
//   busy                 : high while computing
//   state                : FSM state for debug
// -----------------------------------------------------------------------------
module matrix_multiply_param
    import matmul_pkg::*;
#(
    parameter  int N      = 3,
    parameter  int W      = 3,
    parameter  int SIGNED = 0,
    localparam int RW     = calc_rw(N, W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*N*W-1:0]  mat_a,
    input  logic [N*N*W-1:0]  mat_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*N*RW-1:0] result,
    output logic              busy,
    output logic [1:0]        state
);

    localparam int            CW   = (clog2(N) < 1) ? 1 : clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] ONE  = CW'(32'd1);

    state_e              state_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;
    logic [N*N*W-1:0]    a_q;
    logic [N*N*W-1:0]    b_q;
    logic [N*N*RW-1:0]   c_mat_q;
    logic [RW-1:0]       acc_q;
    logic [RW-1:0]       acc_d;
    logic [CW-1:0]       row_q;
    logic [CW-1:0]       col_q;
    logic [CW-1:0]       k_q;
    logic [W-1:0]        a_op_s;
    logic [W-1:0]        b_op_s;

    // Operand fetch: A[row][k] and B[k][col] from the captured matrices.
    always_comb begin
        a_op_s = a_q[(int'(row_q) * N + int'(k_q)) * W +: W];
        b_op_s = b_q[(int'(k_q) * N + int'(col_q)) * W +: W];
    end

    mac_unit #(
        .W      (W),
        .RW     (RW),
        .SIGNED (SIGNED)
    ) u_mac (
        .a_i   (a_op_s),
        .b_i   (b_op_s),
        .acc_i (acc_q),
        .sum_o (acc_d)
    );

    // FSM, counters, operand/result registers and registered handshake flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            c_mat_q     <= '0;
            acc_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            k_q         <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= mat_a;
                        b_q        <= mat_b;
                        acc_q      <= '0;
                        row_q      <= '0;
                        col_q      <= '0;
                        k_q        <= '0;
                        state_q    <= ST_COMPUTE;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    if (k_q == LAST) begin
                        // Last term of the dot product: store it, restart acc.
                        c_mat_q[(int'(row_q) * N + int'(col_q)) * RW +: RW] <= acc_d;
                        acc_q <= '0;
                        k_q   <= '0;
                        if (col_q == LAST) begin
                            col_q <= '0;
                            if (row_q == LAST) begin
                                row_q       <= '0;
                                state_q     <= ST_DONE;
                                busy_q      <= 1'b0;
                                out_valid_q <= 1'b1;
                            end else begin
                                row_q <= row_q + ONE;
                            end
                        end else begin
                            col_q <= col_q + ONE;
                        end
                    end else begin
                        acc_q <= acc_d;
                        k_q   <= k_q + ONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    // Illegal encoding: recover to IDLE without presenting data.
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = c_mat_q;
    assign state     = state_q;

endmodule

// File: tb/tb_matrix_multiply_param.sv
// -----------------------------------------------------------------------------
// tb_matrix_multiply_param
// Several parameterisations of matrix_multiply_param share one clock/reset.
// Directed table vectors, back-pressure and mid-compute reset sequences, then
// randomized back-to-back operations checked against an arithmetic model.
// -----------------------------------------------------------------------------
module tb_matrix_multiply_param;
    import matmul_pkg::*;

    localparam int NG  = 7;
    localparam int PER = 10;
    localparam int CN  [NG] = '{3, 3, 3, 2, 2, 4, 4};
    localparam int CWD [NG] = '{4, 3, 3, 4, 4, 3, 3};
    localparam int CS  [NG] = '{0, 0, 1, 0, 1, 0, 1};

    logic        clk;
    logic        rst_n;
    logic        iv   [NG];
    logic        ordy [NG];
    logic [63:0] ma   [NG];
    logic [63:0] mb   [NG];
    wire         ir   [NG];
    wire         ov   [NG];
    wire         bz   [NG];
    wire [1:0]   st   [NG];
    wire [159:0] res  [NG];

    for (genvar g = 0; g < NG; g++) begin : g_dut
        localparam int GN  = CN[g];
        localparam int GW  = CWD[g];
        localparam int GRW = calc_rw(GN, GW);
        wire [GN*GN*GRW-1:0] r_w;
        matrix_multiply_param #(.N(GN), .W(GW), .SIGNED(CS[g])) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .mat_a     (ma[g][GN*GN*GW-1:0]),
            .mat_b     (mb[g][GN*GN*GW-1:0]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .result    (r_w),
            .busy      (bz[g]),
            .state     (st[g])
        );
        assign res[g] = 160'(r_w);
    end

    initial clk = 1'b0;
    always #(PER/2) clk = ~clk;

    int n_chk;
    int n_err;

    task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [159:0] put(logic [159:0] v, int idx, int w, longint val);
        logic [159:0] m;
        logic [159:0] x;
        m = (160'd1 << w) - 160'd1;
        x = 160'(val) & m;
        return v | (x << (idx * w));
    endfunction

    function automatic longint get(logic [159:0] v, int idx, int w, int s);
        longint x;
        x = longint'((v >> (idx * w)) & ((160'd1 << w) - 160'd1));
        if (s != 0 && x >= (64'sd1 <<< (w - 1))) x = x - (64'sd1 <<< w);
        return x;
    endfunction

    // Reference: plain integer dot products, result truncated to RW bits.
    function automatic logic [159:0] model(int n, int w, int s, logic [159:0] a, logic [159:0] b);
        logic [159:0] r;
        longint acc;
        r = '0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                acc = 0;
                for (int k = 0; k < n; k++) acc += get(a, i*n+k, w, s) * get(b, k*n+j, w, s);
                r = put(r, i*n+j, calc_rw(n, w), acc);
            end
        end
        return r;
    endfunction

    function automatic logic [159:0] fill(int cnt, int w, longint val);
        logic [159:0] r;
        r = '0;
        for (int i = 0; i < cnt; i++) r = put(r, i, w, val);
        return r;
    endfunction

    function automatic logic [159:0] rnd(int bits);
        logic [159:0] v;
        v = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return v & ((160'd1 << bits) - 160'd1);
    endfunction

    task automatic capture(input int g, input logic [159:0] a, input logic [159:0] b, output time tc);
        @(negedge clk);
        ma[g] = a[63:0];
        mb[g] = b[63:0];
        iv[g] = 1'b1;
        for (int i = 0; i < 200 && !ir[g]; i++) @(negedge clk);
        if (!ir[g]) begin
            n_chk++;
            n_err++;
            $display("FAIL capture_timeout: in_ready=0 required=1 (inst %0d)", g);
        end
        @(posedge clk);
        tc = $time;
    endtask

    task automatic wait_result(input int g, input logic [159:0] exp, input time tc,
                               input string nm, input bit scramble, input bit keep_valid);
        int  n3;
        bit  seen;
        n3   = CN[g] * CN[g] * CN[g];
        seen = 1'b0;
        for (int i = 0; i < n3 + 8; i++) begin
            @(negedge clk);
            if (!keep_valid) iv[g] = 1'b0;
            if (i == 0) check({nm, "_busy_hi"}, 160'(bz[g]), 160'd1);
            if (scramble) begin
                ma[g] = {$urandom, $urandom};
                mb[g] = {$urandom, $urandom};
            end
            if (ov[g]) begin
                seen = 1'b1;
                break;
            end
        end
        check({nm, "_out_valid"}, 160'(seen), 160'd1);
        if (seen) begin
            check({nm, "_latency"}, 160'(($time - PER/2 - tc) / PER), 160'(n3));
            check({nm, "_result"}, res[g], exp);
            check({nm, "_busy_lo"}, 160'(bz[g]), 160'd0);
            check({nm, "_in_ready_lo"}, 160'(ir[g]), 160'd0);
        end
    endtask

    typedef struct {
        int           g;
        logic [159:0] a;
        logic [159:0] b;
        logic [159:0] exp;
        string        nm;
    } vec_t;

    vec_t         tbl [4];
    time          tc;
    time          t_prev;
    logic [159:0] a;
    logic [159:0] b;
    logic [159:0] e;

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        for (int g = 0; g < NG; g++) begin
            iv[g] = 1'b0; ordy[g] = 1'b1; ma[g] = '0; mb[g] = '0;
        end

        // Directed vectors: identity x 1..9, unsigned worst case, signed cases.
        tbl[0].g = 0; tbl[0].a = '0; tbl[0].b = '0; tbl[0].exp = '0; tbl[0].nm = "identity";
        for (int r = 0; r < 3; r++) tbl[0].a = put(tbl[0].a, r*3+r, 4, 1);
        for (int i = 0; i < 9; i++) begin
            tbl[0].b   = put(tbl[0].b, i, 4, i + 1);
            tbl[0].exp = put(tbl[0].exp, i, 10, i + 1);
        end
        tbl[1] = '{1, fill(9, 3, 7),  fill(9, 3, 7),  fill(9, 8, 147), "worst_unsigned"};
        tbl[2] = '{2, fill(9, 3, -4), fill(9, 3, -4), fill(9, 8, 48),  "signed_neg_neg"};
        tbl[3] = '{2, fill(9, 3, -4), fill(9, 3, 3),  fill(9, 8, -36), "signed_neg_pos"};

        repeat (3) @(negedge clk);
        for (int g = 0; g < NG; g++) begin
            check("reset_state", 160'(st[g]), 160'd0);
            check("reset_result", res[g], 160'd0);
        end
        check("reset_out_valid", 160'(ov[0]), 160'd0);
        check("reset_busy", 160'(bz[0]), 160'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", 160'(ir[0]), 160'd1);

        for (int i = 0; i < 4; i++) begin
            capture(tbl[i].g, tbl[i].a, tbl[i].b, tc);
            wait_result(tbl[i].g, tbl[i].exp, tc, tbl[i].nm, 1'b0, 1'b0);
        end

        // Back-pressure: DONE held for 10 cycles, in_valid pulses ignored.
        @(negedge clk);
        ordy[0] = 1'b0;
        a = rnd(36); b = rnd(36); e = model(3, 4, 0, a, b);
        capture(0, a, b, tc);
        wait_result(0, e, tc, "bp", 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_result_hold", res[0], e);
            check("bp_out_valid", 160'(ov[0]), 160'd1);
            check("bp_in_ready", 160'(ir[0]), 160'd0);
            check("bp_state", 160'(st[0]), 160'd2);
            iv[0] = (i % 2 == 0) ? 1'b1 : 1'b0;
            ma[0] = {$urandom, $urandom};
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        @(negedge clk);
        check("handoff_state", 160'(st[0]), 160'd0);
        check("handoff_out_valid", 160'(ov[0]), 160'd0);
        check("handoff_in_ready", 160'(ir[0]), 160'd1);
        check("handoff_result_kept", res[0], e);
        @(negedge clk);
        check("no_queued_capture", 160'(st[0]), 160'd0);

        // Reset in the middle of COMPUTE, then a fresh operation.
        a = rnd(36); b = rnd(36);
        capture(0, a, b, tc);
        repeat (10) begin
            @(negedge clk);
            iv[0] = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_state", 160'(st[0]), 160'd0);
        check("midrst_out_valid", 160'(ov[0]), 160'd0);
        check("midrst_busy", 160'(bz[0]), 160'd0);
        check("midrst_result", res[0], 160'd0);
        rst_n = 1'b1;
        @(negedge clk);
        a = rnd(36); b = rnd(36); e = model(3, 4, 0, a, b);
        capture(0, a, b, tc);
        wait_result(0, e, tc, "after_rst", 1'b0, 1'b0);

        // Randomized back-to-back with out_ready high: results and cadence.
        for (int g = 3; g < NG; g++) begin
            int n;
            int w;
            n = CN[g];
            w = CWD[g];
            t_prev = 0;
            for (int t = 0; t < 100; t++) begin
                a = rnd(n*n*w); b = rnd(n*n*w); e = model(n, w, CS[g], a, b);
                capture(g, a, b, tc);
                if (t > 0) check("cadence", 160'((tc - t_prev) / PER), 160'(n*n*n + 2));
                t_prev = tc;
                wait_result(g, e, tc, "random", 1'b1, 1'b1);
            end
            @(negedge clk);
            iv[g] = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #(PER * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
